// File: rtl/vga_pkg.sv
// vga_pkg: colour constants, mode encoding and the 8-entry palette for the VGA pattern generator
package vga_pkg;
    localparam logic [11:0] WHITE   = 12'hFFF;
    localparam logic [11:0] BLACK   = 12'h000;
    localparam logic [11:0] RED     = 12'h00F;
    localparam logic [11:0] GREEN   = 12'h0F0;
    localparam logic [11:0] BLUE    = 12'hF00;
    localparam logic [11:0] YELLOW  = 12'h0FF;
    localparam logic [11:0] CYAN    = 12'hFF0;
    localparam logic [11:0] MAGENTA = 12'hF0F;
    localparam logic [1:0] MODE_VBAR   = 2'd0;
    localparam logic [1:0] MODE_HBAR   = 2'd1;
    localparam logic [1:0] MODE_CHECK  = 2'd2;
    localparam logic [1:0] MODE_SCROLL = 2'd3;
    function automatic logic [11:0] palette(input logic [2:0] idx);
        case (idx)
            3'd0: return WHITE;
            3'd1: return BLACK;
            3'd2: return RED;
            3'd3: return GREEN;
            3'd4: return BLUE;
            3'd5: return YELLOW;
            3'd6: return CYAN;
            default: return MAGENTA;
        endcase
    endfunction
endpackage

// File: rtl/vga_scroll_ctrl.sv
// vga_scroll_ctrl: frame-boundary mode shadow register and wrapping scroll offset
// Ports: clk_25/rst_n clock and async active-low reset; frame_start first-cycle-of-frame pulse;
//        mode_req requested mode; mode_cur latched mode; scroll_off horizontal scroll offset (0..H_DISP-1)
module vga_scroll_ctrl import vga_pkg::*; #(
    parameter int H_DISP      = 640,
    parameter int SCROLL_STEP = 4
) (
    input  logic       clk_25,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic [1:0] mode_req,
    output logic [1:0] mode_cur,
    output logic [9:0] scroll_off
);
    logic [10:0] sum;
    assign sum = {1'b0, scroll_off} + 11'(SCROLL_STEP);
    // the offset only advances on frames that were already scrolling, so it keys off the old mode
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            mode_cur   <= MODE_VBAR;
            scroll_off <= '0;
        end else if (frame_start) begin
            mode_cur <= mode_req;
            if (mode_cur == MODE_SCROLL)
                scroll_off <= sum >= 11'(H_DISP) ? 10'(sum - 11'(H_DISP)) : sum[9:0];
        end
    end
endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: maps VGA pixel coordinates to 12-bit test-pattern colour with 2-cycle latency
// Ports: clk_25/rst_n pixel clock and async active-low reset; pixel_xpos/pixel_ypos/pixel_valid coordinates;
//        frame_start frame pulse; mode_req requested mode; pixel_data {B,G,R} colour; pixel_valid_o
//        aligned qualifier; mode_cur active mode. Define VGA_PATTERN_BORDER_EN for a white frame border.
module vga_pattern_gen import vga_pkg::*; #(
    parameter int H_DISP      = 640,
    parameter int V_DISP      = 480,
    parameter int N_BANDS     = 8,
    parameter int CHECK_LOG2  = 5,
    parameter int SCROLL_STEP = 4
) (
    input  logic        clk_25,
    input  logic        rst_n,
    input  logic [9:0]  pixel_xpos,
    input  logic [9:0]  pixel_ypos,
    input  logic        pixel_valid,
    input  logic        frame_start,
    input  logic [1:0]  mode_req,
    output logic [11:0] pixel_data,
    output logic        pixel_valid_o,
    output logic [1:0]  mode_cur
);
    logic [9:0]  scroll_off;
    logic [1:0]  mode;
    logic [10:0] xs_sum;
    logic [9:0]  xs, xsel;
    logic [2:0]  vidx, hidx, pat_idx, idx_d, idx1;
    logic        in_range, on1, valid1;
    vga_scroll_ctrl #(.H_DISP(H_DISP), .SCROLL_STEP(SCROLL_STEP)) u_scroll (
        .clk_25     (clk_25),
        .rst_n      (rst_n),
        .frame_start(frame_start),
        .mode_req   (mode_req),
        .mode_cur   (mode_cur),
        .scroll_off (scroll_off)
    );
    // a mode requested on the frame_start cycle already governs that cycle's pixel
    assign mode     = frame_start ? mode_req : mode_cur;
    assign in_range = pixel_valid && pixel_xpos < 10'(H_DISP) && pixel_ypos < 10'(V_DISP);
    assign xs_sum   = {1'b0, pixel_xpos} + {1'b0, scroll_off};
    assign xs       = xs_sum >= 11'(H_DISP) ? 10'(xs_sum - 11'(H_DISP)) : xs_sum[9:0];
    assign xsel     = mode == MODE_SCROLL ? xs : pixel_xpos;
    // 15-bit products keep x*N_BANDS exact for N_BANDS up to 16; only idx mod 8 reaches the palette
    assign vidx     = 3'((15'(xsel) * 15'(N_BANDS)) / 15'(H_DISP));
    assign hidx     = 3'((15'(pixel_ypos) * 15'(N_BANDS)) / 15'(V_DISP));
    assign pat_idx  = mode == MODE_CHECK ? {2'b00, pixel_xpos[CHECK_LOG2] ^ pixel_ypos[CHECK_LOG2]} :
                      mode == MODE_HBAR  ? hidx : vidx;
`ifdef VGA_PATTERN_BORDER_EN
    logic border;
    assign border = pixel_xpos == 10'd0 || pixel_xpos == 10'(H_DISP - 1) ||
                    pixel_ypos == 10'd0 || pixel_ypos == 10'(V_DISP - 1);
    assign idx_d  = border ? 3'd0 : pat_idx;
`else
    assign idx_d  = pat_idx;
`endif
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            idx1          <= '0;
            on1           <= 1'b0;
            valid1        <= 1'b0;
            pixel_data    <= BLACK;
            pixel_valid_o <= 1'b0;
        end else begin
            idx1          <= idx_d;
            on1           <= in_range;
            valid1        <= pixel_valid;
            pixel_data    <= on1 ? palette(idx1) : BLACK;
            pixel_valid_o <= valid1;
        end
    end
endmodule
